round_ctrl: RTL and testbench
=============================

ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 Parameter COLS, default 8: number of top-row (goal) frog cells observed.
REQ-002 Parameter LIVES, default 3: lives at game start, range 1..3.
REQ-003 Parameter WIN_SCORE, default 7: goals needed to win, range 1..7.
REQ-004 Parameter HOLD_CYC, default 50: length in cycles of the post-goal and post-hit hold, minimum 1.
REQ-005 Parameter TIMEOUT_CYC, default 1000: round time limit in cycles; used only under ROUND_CTRL_TIMEOUT_EN.
REQ-006 clk  input  1  system clock; all state changes on posedge.
REQ-007 reset  input  1  synchronous, active-high game reset.
REQ-008 goalRow  input  COLS  lightOn outputs of the goal-row frog cells; any bit high means the frog reached the goal.
REQ-009 hit  input  1  collision of the frog with a hazard, level sampled each cycle.
REQ-010 resetRound  output  1  one-cycle pulse that returns the frog to the start cell (drives startFrog resetRound).
REQ-011 score  output  3  goals achieved, 0..WIN_SCORE.
REQ-012 lives  output  2  lives remaining, 0..LIVES.
REQ-013 playing  output  1  high only in state PLAY.
REQ-014 gameWon  output  1  high only in state WON.
REQ-015 gameOver  output  1  high only in state OVER.

Function
REQ-016 The block SHALL implement the states PLAY, WIN_HOLD, LOSE_HOLD, WON and OVER.
REQ-017 PLAY with |goalRow=1 SHALL, on the next edge, increment score; go to WON if the new score equals WIN_SCORE, otherwise go to WIN_HOLD.
REQ-018 PLAY with hit=1 and goalRow=0 SHALL, on the next edge, decrement lives; go to OVER if the new lives equals 0, otherwise go to LOSE_HOLD.
REQ-019 When goal and hit occur in the same cycle, the goal SHALL take priority and lives SHALL be unchanged.
REQ-020 On the edge that enters WIN_HOLD or LOSE_HOLD, resetRound SHALL go high for exactly one cycle (one-cycle latency from detection); it SHALL be low at all other times.
REQ-021 resetRound SHALL NOT pulse on entry to WON or OVER.
REQ-022 The hold states SHALL last exactly HOLD_CYC cycles, ignoring goalRow and hit, and then return to PLAY.
REQ-023 The hold counter SHALL clear on each entry to a hold state.
REQ-024 WON and OVER SHALL be terminal; only reset leaves them.
REQ-025 score SHALL never exceed WIN_SCORE and lives SHALL never underflow below 0.

Reset
REQ-026 While reset=1 at a posedge, the block SHALL enter PLAY with score=0, lives=LIVES, counters cleared and resetRound=0.
REQ-027 reset SHALL override every state, including mid-hold and the terminal states, and SHALL take priority over a simultaneous goal or hit.

Configuration
REQ-028 With ROUND_CTRL_TIMEOUT_EN defined, a round timer SHALL:
- clear on entry to PLAY and on reset;
- count cycles spent in PLAY;
- on reaching TIMEOUT_CYC-1 with no goal, act exactly as hit=1 for that cycle (REQ-018/019 apply).
REQ-029 Without ROUND_CTRL_TIMEOUT_EN, the block SHALL contain no timer, and lives SHALL change only on hit.

Verification (bench parameters LIVES=3, WIN_SCORE=2, HOLD_CYC=4, TIMEOUT_CYC=10)
REQ-030 Reset for 1 cycle, then hold inputs idle for 5 cycles -> playing=1, score=0, lives=3, resetRound=0 throughout.
REQ-031 Goal with goalRow=8'b0001_0000 for 1 cycle in PLAY:
- next cycle: score=1, resetRound=1 for one cycle, playing=0;
- after 4 cycles: playing=1.
REQ-032 Hit three times, each in PLAY:
- lives 3->2->1, with a resetRound pulse and a 4-cycle hold each;
- third hit -> lives=0, gameOver=1, no pulse;
- later goals are ignored.
REQ-033 Goal and hit in the same cycle -> score increments, lives unchanged.
- Then a second goal -> score=2, gameWon=1, resetRound stays 0.
REQ-034 Assert reset during LOSE_HOLD and during OVER -> next cycle playing=1, score=0, lives=3, resetRound=0.
REQ-035 With ROUND_CTRL_TIMEOUT_EN and 10 idle cycles in PLAY -> lives decrements and resetRound pulses.
- Without the macro, the same stimulus -> lives unchanged.

Source files
------------

// File: rtl/round_ctrl.sv
// Round controller for the frog game: tracks score and lives, sequences goal/hit holds and end states.
// Optional round time limit enabled by defining ROUND_CTRL_TIMEOUT_EN.
module round_ctrl #(
    parameter int unsigned COLS        = 8,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned WIN_SCORE   = 7,
    parameter int unsigned HOLD_CYC    = 50,
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [COLS-1:0] goalRow,
    input  logic            hit,
    output logic            resetRound,
    output logic [2:0]      score,
    output logic [1:0]      lives,
    output logic            playing,
    output logic            gameWon,
    output logic            gameOver
);

    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    // Reject parameter values the score/lives registers cannot represent.
    if (LIVES < 1 || LIVES > 3) begin : g_bad_lives
        $error("round_ctrl: LIVES must be in 1..3");
    end
    if (WIN_SCORE < 1 || WIN_SCORE > 7) begin : g_bad_win
        $error("round_ctrl: WIN_SCORE must be in 1..7");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
        $error("round_ctrl: HOLD_CYC must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("round_ctrl: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        PLAY      = 3'd0,
        WIN_HOLD  = 3'd1,
        LOSE_HOLD = 3'd2,
        WON       = 3'd3,
        OVER      = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [2:0]          score_n;
    logic [1:0]          lives_n;
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_n;
    logic                reset_round_n;
    logic                goal_c;
    logic                hit_eff_c;

    assign goal_c = |goalRow;

`ifdef ROUND_CTRL_TIMEOUT_EN
    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMR_W-1:0] timer, timer_n;
    logic             timeout_c;

    // Time limit expiring counts as a collision for this cycle.
    assign timeout_c = (state == PLAY) && (timer == TMR_W'(TIMEOUT_CYC - 1));
    assign hit_eff_c = hit | timeout_c;

    // Timer only runs while the frog stays in PLAY; any exit or re-entry restarts it.
    always_comb begin
        timer_n = '0;
        if (state == PLAY && state_n == PLAY) begin
            timer_n = timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer <= '0;
        end else begin
            timer <= timer_n;
        end
    end
`else
    assign hit_eff_c = hit;
`endif

    // Next-state, score/lives update and round-restart pulse.
    always_comb begin
        state_n       = state;
        score_n       = score;
        lives_n       = lives;
        hold_cnt_n    = hold_cnt;
        reset_round_n = 1'b0;

        case (state)
            PLAY: begin
                if (goal_c) begin
                    // Goal wins over a coincident hit; lives untouched.
                    if (score < 3'(WIN_SCORE)) begin
                        score_n = score + 3'd1;
                    end
                    if (score_n == 3'(WIN_SCORE)) begin
                        state_n = WON;
                    end else begin
                        state_n       = WIN_HOLD;
                        hold_cnt_n    = '0;
                        reset_round_n = 1'b1;
                    end
                end else if (hit_eff_c) begin
                    if (lives != 2'd0) begin
                        lives_n = lives - 2'd1;
                    end
                    if (lives_n == 2'd0) begin
                        state_n = OVER;
                    end else begin
                        state_n       = LOSE_HOLD;
                        hold_cnt_n    = '0;
                        reset_round_n = 1'b1;
                    end
                end
            end

            WIN_HOLD, LOSE_HOLD: begin
                if (hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                    state_n    = PLAY;
                    hold_cnt_n = '0;
                end else begin
                    hold_cnt_n = hold_cnt + HOLD_W'(1);
                end
            end

            WON, OVER: begin
                state_n = state;
            end

            default: begin
                state_n    = PLAY;
                hold_cnt_n = '0;
            end
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= PLAY;
            score      <= 3'd0;
            lives      <= 2'(LIVES);
            hold_cnt   <= '0;
            resetRound <= 1'b0;
            playing    <= 1'b1;
            gameWon    <= 1'b0;
            gameOver   <= 1'b0;
        end else begin
            state      <= state_n;
            score      <= score_n;
            lives      <= lives_n;
            hold_cnt   <= hold_cnt_n;
            resetRound <= reset_round_n;
            playing    <= (state_n == PLAY);
            gameWon    <= (state_n == WON);
            gameOver   <= (state_n == OVER);
        end
    end

endmodule

// File: tb/tb_round_ctrl.sv
// Scoreboard bench for round_ctrl: a behavioural game model queues expected outputs per cycle.
module tb_round_ctrl;

    localparam int unsigned COLS        = 8;
    localparam int unsigned LIVES       = 3;
    localparam int unsigned WIN_SCORE   = 2;
    localparam int unsigned HOLD_CYC    = 4;
    localparam int unsigned TIMEOUT_CYC = 10;
`ifdef ROUND_CTRL_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct packed {
        logic [2:0] score;
        logic [1:0] lives;
        logic       playing;
        logic       won;
        logic       over;
        logic       rr;
    } obs_t;

    typedef enum int {M_PLAY, M_HOLD, M_WON, M_OVER} mode_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [COLS-1:0] goalRow;
    logic            hit;
    logic            resetRound;
    logic [2:0]      score;
    logic [1:0]      lives;
    logic            playing, gameWon, gameOver;

    int    n_checks = 0;
    int    n_fail   = 0;
    obs_t  exp_q[$];
    obs_t  obs_q[$];

    mode_t m_mode  = M_PLAY;
    int    m_score = 0;
    int    m_lives = LIVES;
    int    m_hold  = 0;
    int    m_timer = 0;
    bit    m_rr    = 1'b0;

    round_ctrl #(
        .COLS(COLS), .LIVES(LIVES), .WIN_SCORE(WIN_SCORE),
        .HOLD_CYC(HOLD_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .goalRow(goalRow), .hit(hit),
        .resetRound(resetRound), .score(score), .lives(lives),
        .playing(playing), .gameWon(gameWon), .gameOver(gameOver)
    );

    always #5 clk = ~clk;

    // Drive one cycle, advance the game model, queue expected and observed outputs.
    task automatic drive(input logic rst, input logic [COLS-1:0] g, input logic h);
        obs_t e, o;
        bit   tmo;
        reset   = rst;
        goalRow = g;
        hit     = h;
        if (rst) begin
            m_mode = M_PLAY; m_score = 0; m_lives = LIVES; m_hold = 0; m_timer = 0; m_rr = 1'b0;
        end else begin
            m_rr = 1'b0;
            case (m_mode)
                M_PLAY: begin
                    tmo = TIMEOUT_ON && (m_timer == TIMEOUT_CYC - 1);
                    if (g != '0) begin
                        m_score++;
                        m_timer = 0;
                        if (m_score == WIN_SCORE) m_mode = M_WON;
                        else begin m_mode = M_HOLD; m_hold = HOLD_CYC; m_rr = 1'b1; end
                    end else if (h || tmo) begin
                        m_lives--;
                        m_timer = 0;
                        if (m_lives == 0) m_mode = M_OVER;
                        else begin m_mode = M_HOLD; m_hold = HOLD_CYC; m_rr = 1'b1; end
                    end else begin
                        m_timer++;
                    end
                end
                M_HOLD: begin
                    m_hold--;
                    if (m_hold == 0) m_mode = M_PLAY;
                end
                default: ;
            endcase
        end
        e.score   = 3'(m_score);
        e.lives   = 2'(m_lives);
        e.playing = (m_mode == M_PLAY);
        e.won     = (m_mode == M_WON);
        e.over    = (m_mode == M_OVER);
        e.rr      = m_rr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = '{score: score, lives: lives, playing: playing, won: gameWon, over: gameOver, rr: resetRound};
        obs_q.push_back(o);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        obs_t e, o;
        drive(1'b1, '0, 1'b0);
        idle(5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_sb: got %p want %p", o, e); end
        end
        n_checks++;
        if ({playing, score, lives, resetRound} !== {1'b1, 3'd0, 2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: got play=%b score=%0d lives=%0d rr=%b want 1/0/3/0",
                     playing, score, lives, resetRound);
        end
    endtask

    task automatic test_goal();
        obs_t e, o;
        drive(1'b0, 8'b0001_0000, 1'b0);
        n_checks++;
        if ({score, resetRound, playing} !== {3'd1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL goal_entry: got score=%0d rr=%b play=%b want 1/1/0", score, resetRound, playing);
        end
        idle(1);
        n_checks++;
        if (resetRound !== 1'b0) begin n_fail++; $display("FAIL goal_pulse_len: got rr=%b want 0", resetRound); end
        idle(3);
        n_checks++;
        if (playing !== 1'b1) begin n_fail++; $display("FAIL goal_hold_len: got play=%b want 1", playing); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL goal_sb: got %p want %p", o, e); end
        end
    endtask

    task automatic test_hits();
        obs_t e, o;
        drive(1'b1, '0, 1'b0);
        drive(1'b0, '0, 1'b1);
        n_checks++;
        if ({lives, resetRound} !== {2'd2, 1'b1}) begin
            n_fail++; $display("FAIL hit1: got lives=%0d rr=%b want 2/1", lives, resetRound);
        end
        idle(4);
        drive(1'b0, '0, 1'b1);
        idle(4);
        drive(1'b0, '0, 1'b1);
        n_checks++;
        if ({lives, gameOver, resetRound} !== {2'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL hit3_over: got lives=%0d over=%b rr=%b want 0/1/0", lives, gameOver, resetRound);
        end
        drive(1'b0, 8'h01, 1'b0);
        drive(1'b0, 8'h80, 1'b1);
        n_checks++;
        if ({score, gameOver, playing} !== {3'd0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL over_terminal: got score=%0d over=%b play=%b want 0/1/0", score, gameOver, playing);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL hits_sb: got %p want %p", o, e); end
        end
    endtask

    task automatic test_goal_hit();
        obs_t e, o;
        drive(1'b1, '0, 1'b0);
        drive(1'b0, 8'h04, 1'b1);
        n_checks++;
        if ({score, lives} !== {3'd1, 2'd3}) begin
            n_fail++; $display("FAIL goal_hit_prio: got score=%0d lives=%0d want 1/3", score, lives);
        end
        idle(4);
        drive(1'b0, 8'h02, 1'b0);
        n_checks++;
        if ({score, gameWon, resetRound} !== {3'd2, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL win: got score=%0d won=%b rr=%b want 2/1/0", score, gameWon, resetRound);
        end
        drive(1'b0, 8'hFF, 1'b1);
        idle(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL goal_hit_sb: got %p want %p", o, e); end
        end
    endtask

    task automatic test_reset_override();
        obs_t e, o;
        drive(1'b1, '0, 1'b0);
        drive(1'b0, '0, 1'b1);
        idle(1);
        drive(1'b1, 8'h10, 1'b1);
        n_checks++;
        if ({playing, score, lives, resetRound} !== {1'b1, 3'd0, 2'd3, 1'b0}) begin
            n_fail++; $display("FAIL rst_in_hold: got play=%b score=%0d lives=%0d rr=%b want 1/0/3/0",
                               playing, score, lives, resetRound);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1);
            if (i < 2) idle(4);
        end
        idle(1);
        drive(1'b1, '0, 1'b0);
        n_checks++;
        if ({playing, gameOver, score, lives, resetRound} !== {1'b1, 1'b0, 3'd0, 2'd3, 1'b0}) begin
            n_fail++; $display("FAIL rst_in_over: got play=%b over=%b score=%0d lives=%0d rr=%b want 1/0/0/3/0",
                               playing, gameOver, score, lives, resetRound);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rst_override_sb: got %p want %p", o, e); end
        end
    endtask

    task automatic test_timeout();
        obs_t        e, o;
        logic [1:0]  want_lives;
        logic        want_rr;
        want_lives = TIMEOUT_ON ? 2'd2 : 2'd3;
        want_rr    = TIMEOUT_ON;
        drive(1'b1, '0, 1'b0);
        idle(10);
        n_checks++;
        if ({lives, resetRound} !== {want_lives, want_rr}) begin
            n_fail++; $display("FAIL timeout: got lives=%0d rr=%b want %0d/%b", lives, resetRound, want_lives, want_rr);
        end
        idle(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL timeout_sb: got %p want %p", o, e); end
        end
    endtask

    initial begin
        reset   = 1'b1;
        goalRow = '0;
        hit     = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_goal();
        test_hits();
        test_goal_hit();
        test_reset_override();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
